// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the minisoc single-port RAM between the core instruction bus (ibus)
//   and data bus (dbus). One access is granted per cycle. dbus normally wins;
//   a saturating starvation counter forces an ibus grant after MAX_WAIT
//   consecutive lost cycles. RAM read data (1-cycle latency) is steered back to
//   whichever bus issued the read by a registered owner tag.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   ibus_req/addr            instruction read request and byte address
//   ibus_ready               ibus request accepted this cycle
//   ibus_rvalid/rdata        instruction word, cycle after acceptance
//   dbus_req/write/addr      data request, direction and byte address
//   dbus_wdata/wstrb         write data and byte enables
//   dbus_ready               dbus request accepted this cycle
//   dbus_rvalid/rdata        read data, cycle after a read acceptance
//   ram_en/we/addr/wdata     single-port RAM command (word addressed)
//   ram_rdata                RAM read data, one cycle after a read command
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int RAM_AW   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ibus_req,
    input  logic [AW-1:0]     ibus_addr,
    output logic              ibus_ready,
    output logic              ibus_rvalid,
    output logic [31:0]       ibus_rdata,

    input  logic              dbus_req,
    input  logic              dbus_write,
    input  logic [AW-1:0]     dbus_addr,
    input  logic [31:0]       dbus_wdata,
    input  logic [3:0]        dbus_wstrb,
    output logic              dbus_ready,
    output logic              dbus_rvalid,
    output logic [31:0]       dbus_rdata,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_I,
        RESP_D
    } resp_state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    resp_state_t resp_state;
    resp_state_t resp_state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;
    logic        starved;
    logic        grant_i;
    logic        grant_d;

    // Only the word-index bits of each byte address reach the RAM; the rest
    // wrap on RAM depth or are sub-word offsets.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ibus_addr[AW-1:RAM_AW+2], ibus_addr[1:0],
                                dbus_addr[AW-1:RAM_AW+2], dbus_addr[1:0]};

    // The counter never exceeds the limit, so equality is the starvation test.
    assign starved = (wait_cnt == WAIT_LIMIT);

    // Same-cycle arbitration; reset suppresses every grant so no RAM access
    // or ready can leak out while the block is being reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            grant_i = ibus_req && (!dbus_req || starved);
            grant_d = dbus_req && !grant_i;
        end
    end

    assign ibus_ready = grant_i;
    assign dbus_ready = grant_d;

    // ibus never writes, so the RAM write data is always the dbus data and is
    // only meaningful when ram_we is non-zero.
    assign ram_en    = grant_i | grant_d;
    assign ram_we    = (grant_d && dbus_write) ? dbus_wstrb : 4'b0000;
    assign ram_addr  = grant_i ? ibus_addr[RAM_AW+1:2] : dbus_addr[RAM_AW+1:2];
    assign ram_wdata = dbus_wdata;

    // Starvation counter: counts consecutive cycles ibus asked and lost,
    // saturating at the limit; any grant or idle ibus clears it.
    always_comb begin
        wait_cnt_next = 4'd0;
        if (ibus_req && !grant_i) begin
            wait_cnt_next = starved ? WAIT_LIMIT : wait_cnt + 4'd1;
        end
    end

    // Owner tag for the read response that arrives next cycle. Writes and
    // idle cycles produce no response.
    always_comb begin
        resp_state_next = RESP_NONE;
        if (grant_i) begin
            resp_state_next = RESP_I;
        end else if (grant_d && !dbus_write) begin
            resp_state_next = RESP_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_state <= RESP_NONE;
            wait_cnt   <= 4'd0;
        end else begin
            resp_state <= resp_state_next;
            wait_cnt   <= wait_cnt_next;
        end
    end

    // A response still in flight when reset arrives is dropped, so rvalid is
    // masked during reset as well as cleared at the following edge.
    assign ibus_rvalid = (resp_state == RESP_I) && !rst;
    assign dbus_rvalid = (resp_state == RESP_D) && !rst;
    assign ibus_rdata  = ram_rdata;
    assign dbus_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A bench-side RAM responds to the
//   DUT's RAM port. A behavioural model (grant rule, starvation count, a
//   one-slot expected response and its own copy of memory) is compared
//   against the DUT every cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW       = 32;
    localparam int RAM_AW   = 12;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ibus_req = 1'b0;
    logic [AW-1:0]     ibus_addr = '0;
    logic              ibus_ready;
    logic              ibus_rvalid;
    logic [31:0]       ibus_rdata;
    logic              dbus_req = 1'b0;
    logic              dbus_write = 1'b0;
    logic [AW-1:0]     dbus_addr = '0;
    logic [31:0]       dbus_wdata = '0;
    logic [3:0]        dbus_wstrb = '0;
    logic              dbus_ready;
    logic              dbus_rvalid;
    logic [31:0]       dbus_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [31:0] ram_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    mem_arbiter #(
        .AW(AW), .RAM_AW(RAM_AW), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
        .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
        .dbus_req(dbus_req), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_ready(dbus_ready),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Bench-side single-port RAM driven purely by the DUT's RAM command.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= ram_mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] byte_addr);
        return int'((byte_addr >> 2) % DEPTH);
    endfunction

    task automatic preset(input int word, input logic [31:0] value);
        ram_mem[word] = value;
        ref_mem[word] = value;
    endtask

    task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic [3:0] ws);
        @(posedge clk);
        #1;
        rst        = r;
        ibus_req   = ir;
        ibus_addr  = ia;
        dbus_req   = dr;
        dbus_write = dw;
        dbus_addr  = da;
        dbus_wdata = dwd;
        dbus_wstrb = ws;
    endtask

    // Behavioural model state: consecutive ibus losses (capped), and the
    // response owed next cycle with the data the model's memory holds.
    int          m_lose      = 0;
    logic        m_pend_i    = 1'b0;
    logic        m_pend_d    = 1'b0;
    logic [31:0] m_pend_data = '0;
    logic        m_gi;
    logic        m_gd;
    int          m_word;

    always @(negedge clk) begin
        if (rst) begin
            m_gi = 1'b0;
            m_gd = 1'b0;
        end else begin
            m_gi = ibus_req && (!dbus_req || m_lose >= MAX_WAIT);
            m_gd = dbus_req && !m_gi;
        end
        m_word = m_gi ? word_of(ibus_addr) : word_of(dbus_addr);

        checkOutput("ibus_ready", 32'(ibus_ready), 32'(m_gi));
        checkOutput("dbus_ready", 32'(dbus_ready), 32'(m_gd));
        checkOutput("ram_en", 32'(ram_en), 32'(m_gi || m_gd));
        checkOutput("ram_we", 32'(ram_we), 32'((m_gd && dbus_write) ? dbus_wstrb : 4'b0000));
        if (m_gi || m_gd) checkOutput("ram_addr", 32'(ram_addr), 32'(m_word));
        if (m_gd && dbus_write) checkOutput("ram_wdata", ram_wdata, dbus_wdata);
        checkOutput("ibus_rvalid", 32'(ibus_rvalid), 32'(m_pend_i && !rst));
        checkOutput("dbus_rvalid", 32'(dbus_rvalid), 32'(m_pend_d && !rst));
        if (m_pend_i && !rst) checkOutput("ibus_rdata", ibus_rdata, m_pend_data);
        if (m_pend_d && !rst) checkOutput("dbus_rdata", dbus_rdata, m_pend_data);

        m_pend_i    = m_gi;
        m_pend_d    = m_gd && !dbus_write;
        m_pend_data = ref_mem[m_word];
        if (m_gd && dbus_write) begin
            for (int b = 0; b < 4; b++) begin
                if (dbus_wstrb[b]) ref_mem[m_word][8*b +: 8] = dbus_wdata[8*b +: 8];
            end
        end
        if (rst || !ibus_req || m_gi) m_lose = 0;
        else if (m_lose < MAX_WAIT) m_lose = m_lose + 1;
    end

    string       pattern;
    logic [7:0]  got_grant;
    logic        ireq_v, dreq_v, dwr_v, rst_v;
    logic [31:0] ia_v, da_v, dwd_v;
    logic [3:0]  ws_v;
    logic        i_acc, d_acc;

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[13:6] = 8'h00;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) preset(i, $urandom);

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("reset_ram_en", 32'(ram_en), 32'd0);
        checkOutput("reset_ibus_rvalid", 32'(ibus_rvalid), 32'd0);

        // Lone ibus read of word 4.
        preset(4, 32'hDEADBEEF);
        applyStimulus(0, 1, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("t1_ibus_ready", 32'(ibus_ready), 32'd1);
        checkOutput("t1_ram_addr", 32'(ram_addr), 32'd4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("t1_ibus_rvalid", 32'(ibus_rvalid), 32'd1);
        checkOutput("t1_ibus_rdata", ibus_rdata, 32'hDEADBEEF);
        checkOutput("t1_dbus_rvalid", 32'(dbus_rvalid), 32'd0);

        // Partial write, read back, then a write right behind the read.
        preset(8, 32'hAABBCCDD);
        applyStimulus(0, 0, 0, 1, 1, 32'h20, 32'h11223344, 4'b0011);
        @(negedge clk); #1;
        checkOutput("t2_ram_we", 32'(ram_we), 32'h3);
        checkOutput("t2_dbus_ready_wr", 32'(dbus_ready), 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 32'h20, 0, 0);
        @(negedge clk); #1;
        checkOutput("t2_no_rvalid_for_write", 32'(dbus_rvalid), 32'd0);
        applyStimulus(0, 0, 0, 1, 1, 32'h24, 32'h0, 4'b1111);
        @(negedge clk); #1;
        checkOutput("t6_rvalid_in_write_cycle", 32'(dbus_rvalid), 32'd1);
        checkOutput("t2_dbus_rdata", dbus_rdata, 32'hAABB3344);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("t6_no_rvalid_after_write", 32'(dbus_rvalid), 32'd0);

        // Both buses held: fixed grant rhythm from the starvation rule.
        pattern = "DDDDIDDDDIDD";
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 1, 32'h40, 1, 0, 32'h44, 0, 0);
            @(negedge clk); #1;
            got_grant = ibus_ready ? 8'h49 : (dbus_ready ? 8'h44 : 8'h2D);
            checkOutput($sformatf("t3_grant_%0d", k), 32'(got_grant), 32'(pattern.getc(k)));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Alternating ibus/dbus reads, no idle cycles.
        preset(0, 32'h01010101);
        preset(1, 32'h02020202);
        applyStimulus(0, 1, 32'h0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h4, 0, 0);
        @(negedge clk); #1;
        checkOutput("t4_ibus_rvalid", 32'(ibus_rvalid), 32'd1);
        checkOutput("t4_ibus_rdata", ibus_rdata, 32'h01010101);
        checkOutput("t4_dbus_ready", 32'(dbus_ready), 32'd1);
        applyStimulus(0, 1, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("t4_dbus_rvalid", 32'(dbus_rvalid), 32'd1);
        checkOutput("t4_dbus_rdata", dbus_rdata, 32'h02020202);
        checkOutput("t4_ibus_rvalid_off", 32'(ibus_rvalid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, (k % 2) == 0, 32'h0, (k % 2) == 1, 0, 32'h4, 0, 0);
        end

        // Reset right after an ibus accept drops the response.
        applyStimulus(0, 1, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("t5_accept", 32'(ibus_ready), 32'd1);
        applyStimulus(1, 1, 32'h10, 1, 0, 32'h8, 0, 0);
        @(negedge clk); #1;
        checkOutput("t5_rvalid_dropped", 32'(ibus_rvalid), 32'd0);
        checkOutput("t5_ready_in_rst", 32'(ibus_ready), 32'd0);
        checkOutput("t5_ram_en_in_rst", 32'(ram_en), 32'd0);
        applyStimulus(0, 1, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("t5_rvalid_after_rst", 32'(ibus_rvalid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("t5_fresh_rdata", ibus_rdata, 32'hDEADBEEF);

        // Randomized traffic; requests are mostly held until accepted.
        ireq_v = 0; dreq_v = 0; dwr_v = 0;
        ia_v = 0; da_v = 0; dwd_v = 0; ws_v = 0;
        i_acc = 0; d_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!ireq_v || i_acc || $urandom_range(0, 9) == 0) begin
                ireq_v = $urandom_range(0, 2) != 0;
                ia_v   = rand_addr();
            end
            if (!dreq_v || d_acc || $urandom_range(0, 9) == 0) begin
                dreq_v = $urandom_range(0, 2) != 0;
                dwr_v  = $urandom_range(0, 9) < 4;
                da_v   = rand_addr();
                dwd_v  = $urandom;
                ws_v   = 4'($urandom_range(0, 15));
            end
            rst_v = $urandom_range(0, 99) == 0;
            applyStimulus(rst_v, ireq_v, ia_v, dreq_v, dwr_v, da_v, dwd_v, ws_v);
            @(negedge clk); #1;
            i_acc = ibus_ready;
            d_acc = dbus_ready;
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
